// File: rtl/sha256_msg_padder_if.sv
// Message-stream and SHA-256 core handshake bundle for the message padder.
interface sha256_msg_padder_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic        in_ready;
    logic [31:0] wrapper_data;
    logic        wrapper_data_valid;
    logic        wrapper_data_request;
    logic        core_start;
    logic        core_first;
    logic        core_done;
    logic        busy;
    logic        msg_done;
    logic        err_nbytes;

    modport master (
        input  in_data, in_valid, in_last, in_nbytes, wrapper_data_request, core_done,
        output in_ready, wrapper_data, wrapper_data_valid, core_start, core_first,
               busy, msg_done, err_nbytes
    );

    modport slave (
        output in_data, in_valid, in_last, in_nbytes, wrapper_data_request, core_done,
        input  in_ready, wrapper_data, wrapper_data_valid, core_start, core_first,
               busy, msg_done, err_nbytes
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a byte-counted word stream into padded 512-bit blocks,
// handing them to the core 16 words at a time with a start/done handshake per block.
module sha256_msg_padder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    sha256_msg_padder_if.master  bus
);
    localparam int unsigned WCNT_W = 5;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_ZERO, S_LEN, S_DRAIN, S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   out_q, out_d;
    logic                out_v_q, out_v_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic                pad_pending_q, pad_pending_d;
    logic                len_pending_q, len_pending_d;
    logic                msg_fin_q, msg_fin_d;
    logic                last_blk_q, last_blk_d;
    logic                first_q, first_d;
    logic                msg_done_q, msg_done_d;
    logic                err_q, err_d;

    logic                xfer_c, load_ok_c, in_ready_c, accept_c, bad_nb_c, load_c;
    logic [WCNT_W-1:0]   wcnt_inc_c;
    logic [2:0]          nb_c;
    logic [WORD_W-1:0]   last_word_c, load_data_c;
    logic [63:0]         bit_len_c;

    // Where to go once the 0x80 byte sits at word position w-1.
    function automatic state_t route_f(input logic [WCNT_W-1:0] w);
        if (w == WCNT_W'(14))      return S_LEN;
        else if (w == WCNT_W'(16)) return S_DRAIN;
        else                       return S_ZERO;
    endfunction

    assign xfer_c     = out_v_q & bus.wrapper_data_request;
    assign load_ok_c  = ~out_v_q | xfer_c;
    assign wcnt_inc_c = wcnt_q + WCNT_W'(1);
    assign nb_c       = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
    assign bit_len_c  = 64'({byte_cnt_q, 3'b000});
    assign in_ready_c = (state_q == S_DATA) && !pad_pending_q && load_ok_c
                        && (wcnt_q < WCNT_W'(16));
    assign accept_c   = bus.in_valid & in_ready_c;
    assign bad_nb_c   = (bus.in_nbytes > 3'd4) | (!bus.in_last & (bus.in_nbytes != 3'd4));

    // Final partial word: keep the valid bytes, append 0x80, clear the rest.
    always_comb begin
        last_word_c = bus.in_data;
        case (nb_c)
            3'd0:    last_word_c = 32'h8000_0000;
            3'd1:    last_word_c = {bus.in_data[31:24], 24'h80_0000};
            3'd2:    last_word_c = {bus.in_data[31:16], 16'h8000};
            3'd3:    last_word_c = {bus.in_data[31:8], 8'h80};
            default: last_word_c = bus.in_data;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        byte_cnt_d    = byte_cnt_q;
        pad_pending_d = pad_pending_q;
        len_pending_d = len_pending_q;
        msg_fin_d     = msg_fin_q;
        last_blk_d    = last_blk_q;
        first_d       = first_q;
        msg_done_d    = 1'b0;
        err_d         = err_q | (accept_c & bad_nb_c);
        load_c        = 1'b0;
        load_data_c   = '0;

        if (accept_c) begin
            byte_cnt_d = byte_cnt_q + LEN_W'(nb_c);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_START;
                    first_d = 1'b1;
                end
            end
            S_START: begin
                wcnt_d = '0;
                if (msg_fin_q) begin
                    len_pending_d = 1'b0;
                    state_d       = S_ZERO;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (pad_pending_q) begin
                    if (load_ok_c) begin
                        load_c        = 1'b1;
                        load_data_c   = 32'h8000_0000;
                        wcnt_d        = wcnt_inc_c;
                        pad_pending_d = 1'b0;
                        msg_fin_d     = 1'b1;
                        len_pending_d = wcnt_inc_c > WCNT_W'(14);
                        state_d       = route_f(wcnt_inc_c);
                    end
                end else if (accept_c) begin
                    load_c = 1'b1;
                    wcnt_d = wcnt_inc_c;
                    if (!bus.in_last || nb_c == 3'd4) begin
                        load_data_c   = bus.in_data;
                        pad_pending_d = bus.in_last;
                        if (wcnt_inc_c == WCNT_W'(16)) state_d = S_DRAIN;
                    end else begin
                        load_data_c   = last_word_c;
                        msg_fin_d     = 1'b1;
                        len_pending_d = wcnt_inc_c > WCNT_W'(14);
                        state_d       = route_f(wcnt_inc_c);
                    end
                end
            end
            S_ZERO: begin
                if (load_ok_c) begin
                    load_c = 1'b1;
                    wcnt_d = wcnt_inc_c;
                    if (wcnt_inc_c == WCNT_W'(16)) begin
                        state_d = S_DRAIN;
                    end else if (wcnt_inc_c == WCNT_W'(14) && !len_pending_q) begin
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (load_ok_c) begin
                    load_c = 1'b1;
                    wcnt_d = wcnt_inc_c;
                    if (wcnt_q == WCNT_W'(14)) begin
                        load_data_c = bit_len_c[63:32];
                    end else begin
                        load_data_c = bit_len_c[31:0];
                        last_blk_d  = 1'b1;
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_v_q) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    if (last_blk_q) begin
                        msg_done_d    = 1'b1;
                        state_d       = S_IDLE;
                        byte_cnt_d    = '0;
                        msg_fin_d     = 1'b0;
                        last_blk_d    = 1'b0;
                        len_pending_d = 1'b0;
                        pad_pending_d = 1'b0;
                        first_d       = 1'b0;
                    end else begin
                        state_d = S_START;
                        first_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_d   = load_c ? load_data_c : out_q;
        out_v_d = load_c | (out_v_q & ~xfer_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            out_q         <= '0;
            out_v_q       <= 1'b0;
            wcnt_q        <= '0;
            byte_cnt_q    <= '0;
            pad_pending_q <= 1'b0;
            len_pending_q <= 1'b0;
            msg_fin_q     <= 1'b0;
            last_blk_q    <= 1'b0;
            first_q       <= 1'b0;
            msg_done_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_q         <= out_d;
            out_v_q       <= out_v_d;
            wcnt_q        <= wcnt_d;
            byte_cnt_q    <= byte_cnt_d;
            pad_pending_q <= pad_pending_d;
            len_pending_q <= len_pending_d;
            msg_fin_q     <= msg_fin_d;
            last_blk_q    <= last_blk_d;
            first_q       <= first_d;
            msg_done_q    <= msg_done_d;
            err_q         <= err_d;
        end
    end

    assign bus.in_ready           = in_ready_c;
    assign bus.wrapper_data       = out_q;
    assign bus.wrapper_data_valid = out_v_q;
    assign bus.core_start         = (state_q == S_START);
    assign bus.core_first         = first_q & (state_q == S_START);
    assign bus.busy               = (state_q != S_IDLE);
    assign bus.msg_done           = msg_done_q;
    assign bus.err_nbytes         = err_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: message vectors against a byte-level padding model,
// with a small core model answering start/done, plus reset and byte-count error sequences.
module tb_sha256_msg_padder;
    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    typedef struct {
        int unsigned len;
        bit          abc;
        int unsigned exp_blocks;
        bit          bp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.LEN_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Padding from the definition: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
    function automatic wq_t model_words(input bq_t m);
        bq_t         b;
        wq_t         w;
        logic [63:0] bl;
        b  = m;
        bl = 64'(m.size()) * 64'd8;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int i = 7; i >= 0; i--) b.push_back(bl[8*i +: 8]);
        for (int i = 0; i < b.size(); i += 4) w.push_back({b[i], b[i+1], b[i+2], b[i+3]});
        return w;
    endfunction

    task automatic idle_inputs();
        bus.in_valid             = 1'b0;
        bus.in_last              = 1'b0;
        bus.in_nbytes            = 3'd4;
        bus.in_data              = '0;
        bus.wrapper_data_request = 1'b0;
        bus.core_done            = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_wdata"}, 64'(bus.wrapper_data), 64'd0);
        chk({tag, "_wvalid"}, 64'(bus.wrapper_data_valid), 64'd0);
        chk({tag, "_start"}, 64'({bus.core_start, bus.core_first}), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_msg_done"}, 64'(bus.msg_done), 64'd0);
        chk({tag, "_err"}, 64'(bus.err_nbytes), 64'd0);
    endtask

    task automatic run_msg(input int unsigned len, input bit abc, input int unsigned exp_blocks,
                           input bit bp, input bit spurious);
        bq_t  msg;
        wq_t  exp_w, got, in_w;
        int   in_nb[$];
        int   nw, wi, starts, blk_words, done_delay, cyc;
        bit   outstanding, finished;
        logic [7:0] bytes4 [4];

        if (abc) begin
            msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        end else begin
            for (int i = 0; i < int'(len); i++) msg.push_back(8'($urandom));
        end
        exp_w = model_words(msg);

        nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < 4; k++)
                bytes4[k] = (4*i + k < msg.size()) ? msg[4*i + k] : (abc ? 8'h00 : 8'($urandom));
            in_w.push_back({bytes4[0], bytes4[1], bytes4[2], bytes4[3]});
            in_nb.push_back((i == nw - 1) ? (msg.size() - 4*i) : 4);
        end

        wi = 0; starts = 0; blk_words = 0; done_delay = 0;
        outstanding = 1'b0; finished = 1'b0;
        for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (wi < nw && (!bp || $urandom_range(0, 3) != 0)) begin
                bus.in_valid  = 1'b1;
                bus.in_data   = in_w[wi];
                bus.in_last   = (wi == nw - 1);
                bus.in_nbytes = 3'(in_nb[wi]);
            end else begin
                bus.in_valid  = 1'b0;
                bus.in_data   = $urandom;
                bus.in_last   = 1'b0;
                bus.in_nbytes = 3'd4;
            end
            bus.wrapper_data_request = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.core_done = (done_delay == 1);
            if (done_delay == 1) outstanding = 1'b0;
            if (done_delay > 0) done_delay--;
            if (spurious && blk_words > 0 && blk_words < 16 && $urandom_range(0, 9) == 0)
                bus.core_done = 1'b1;
            #1;
            if (bus.in_valid && bus.in_ready) wi++;
            if (bp && bus.wrapper_data_valid && !bus.wrapper_data_request)
                chk("in_ready_when_full", 64'(bus.in_ready), 64'd0);
            if (bus.wrapper_data_valid && bus.wrapper_data_request) begin
                got.push_back(bus.wrapper_data);
                blk_words++;
                if (blk_words == 16) done_delay = 3 + int'($urandom_range(0, 4));
            end
            if (bus.core_start) begin
                starts++;
                chk($sformatf("core_first_blk%0d", starts), 64'(bus.core_first), 64'(starts == 1));
                chk("start_before_done", 64'(outstanding), 64'd0);
                outstanding = 1'b1;
                blk_words   = 0;
            end
            if (bus.msg_done) finished = 1'b1;
        end

        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout len=%0d words_got=%0d required=%0d", len, got.size(), exp_w.size());
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("msg_done_pulse", 64'({bus.msg_done, bus.busy}), 64'd0);
        chk("err_clean", 64'(bus.err_nbytes), 64'd0);
        chk($sformatf("inputs_used_len%0d", len), 64'(wi), 64'(nw));
        chk($sformatf("starts_len%0d", len), 64'(starts), 64'(exp_blocks));
        chk($sformatf("nwords_len%0d", len), 64'(got.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got.size(); i++)
            chk($sformatf("word_len%0d_i%0d", len, i), 64'(got[i]), 64'(exp_w[i]));
    endtask

    vec_t vecs [11];

    initial begin
        int   ln;
        bit   seen;
        vecs[0]  = '{3,   1'b1, 1, 1'b0};
        vecs[1]  = '{0,   1'b0, 1, 1'b0};
        vecs[2]  = '{55,  1'b0, 1, 1'b0};
        vecs[3]  = '{56,  1'b0, 2, 1'b0};
        vecs[4]  = '{56,  1'b0, 2, 1'b1};
        vecs[5]  = '{60,  1'b0, 2, 1'b1};
        vecs[6]  = '{63,  1'b0, 2, 1'b0};
        vecs[7]  = '{64,  1'b0, 2, 1'b1};
        vecs[8]  = '{119, 1'b0, 2, 1'b1};
        vecs[9]  = '{120, 1'b0, 3, 1'b1};
        vecs[10] = '{4,   1'b0, 1, 1'b1};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        foreach (vecs[i])
            run_msg(vecs[i].len, vecs[i].abc, vecs[i].exp_blocks, vecs[i].bp, vecs[i].bp);

        for (int r = 0; r < 6; r++) begin
            ln = int'($urandom_range(0, 150));
            run_msg(ln, 1'b0, (ln + 9 + 63) / 64, 1'b1, 1'b1);
        end

        // Abort a message mid-block with reset, then feed an illegal non-last byte count.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.in_nbytes = 3'd4;
            bus.in_data = $urandom; bus.wrapper_data_request = 1'b0;
        end
        #1;
        chk("midblock_busy", 64'({bus.busy, bus.wrapper_data_valid}), 64'b11);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.in_nbytes = 3'd2;
        bus.wrapper_data_request = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            chk("no_msg_done_after_abort", 64'(bus.msg_done), 64'd0);
            if (bus.in_valid && bus.in_ready) seen = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("bad_nbytes_accepted", 64'(seen), 64'd1);
        chk("err_nbytes_set", 64'(bus.err_nbytes), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("err_nbytes_sticky", 64'(bus.err_nbytes), 64'd1);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        check_all_zero("reset_clears_err");
        @(negedge clk);
        reset = 1'b0;
        run_msg(55, 1'b0, 1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
